// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
// Shared types and constants for the SRAM round-robin arbiter.
//   port_idx_t : requester index, wide enough for the largest port count (8)
//   rd_tag_t   : {valid, port} entry carried by the read-return tag pipeline
//   *_IDLE     : pad control levels driven when no access is on the pads
// The command struct (sram_cmd_t) depends on the top's DW/AW parameters, so
// it is declared inside sram_rr_arbiter where those widths are known.
package sram_arb_pkg;

  localparam int PIDX_W = 3;  // clog2 of the maximum port count (8)

  typedef logic [PIDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t port;
  } rd_tag_t;

  localparam logic CE_N_IDLE  = 1'b1;
  localparam logic WE_N_IDLE  = 1'b1;
  localparam logic OE_N_IDLE  = 1'b1;
  localparam logic DQ_OE_IDLE = 1'b0;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. The search starts at i_ptr and wraps;
// the first requester found wins.
// Ports:
//   i_req [N]  request vector
//   i_ptr [IW] index where the search starts (must be < N)
//   o_gnt [N]  one-hot winner (all zero when nothing requests)
//   o_idx [IW] winner index
//   o_any      at least one request present
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  logic [IW:0]  w_off;
  logic [IW:0]  w_sum;

  // Rotate the requests so bit 0 is the port at i_ptr; the doubled vector
  // takes care of the wrap.
  assign w_rot = N'({i_req, i_req} >> i_ptr);

  // Lowest set bit of the rotated vector is the distance from i_ptr.
  always_comb begin
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = (IW+1)'(j);
    end
  end

  assign w_sum = {1'b0, i_ptr} + w_off;
  assign o_any = |i_req;
  assign o_idx = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : w_sum[IW-1:0];
  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
// Shares one asynchronous single-port SRAM between NPORT requesters with
// round-robin arbitration, at most one access per cycle. Read data is routed
// back to the issuing port through a {valid, port} tag pipeline matched to
// the SRAM read latency.
//
// Handshake: a port holds req with we/addr/wdata stable; the transfer happens
// in the cycle its gnt is high (gnt is combinational from req, ptr and en).
// The port may raise req again the very next cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   en                    0 blocks new grants (in-flight reads still return)
//   req/we [NPORT]        per-port request and direction (1 = write)
//   addr  [NPORT*AW]      per-port address, port 0 in the LSBs
//   wdata [NPORT*DW]      per-port write data, port 0 in the LSBs
//   gnt    [NPORT]        one-hot accept
//   rvalid [NPORT]        one-hot read-return strobe; rdata shared by all ports
//   sram_*                registered pad controls, address and write data;
//                         sram_dq_rd is the pad read data
//
// Optional feature (macro SRAM_ARB_TURNAROUND_EN): when the pads currently
// carry a read and the winning request is a write, the grant is withheld for
// one cycle so the pads idle between the two and DQ is never driven straight
// after the SRAM drove it.
//
// Timing: gnt in cycle t, pads in t+1, sram_dq_rd sampled at the end of
// t+RD_LAT, rvalid/rdata in t+1+RD_LAT.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DW     = 8,
  parameter int AW     = 19,
  parameter int NPORT  = 2,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    we,
  input  logic [NPORT*AW-1:0] addr,
  input  logic [NPORT*DW-1:0] wdata,
  output logic [NPORT-1:0]    gnt,
  output logic [NPORT-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       sram_addr,
  output logic                sram_ce_n,
  output logic                sram_we_n,
  output logic                sram_oe_n,
  output logic [DW-1:0]       sram_dq_wr,
  output logic                sram_dq_oe,
  input  logic [DW-1:0]       sram_dq_rd
);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } sram_cmd_t;

  logic [NPORT-1:0] w_pick_gnt;
  port_idx_t        w_pick_idx;
  logic             w_pick_any;
  port_idx_t        w_ptr_next;
  sram_cmd_t        w_win;
  logic             w_bubble;
  logic             w_fire;

  port_idx_t        r_ptr;
  logic             r_ce_n;
  logic             r_we_n;
  logic             r_oe_n;
  logic             r_dq_oe;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_dq_wr;
  logic [DW-1:0]    r_rdata;
  // Stages 0..RD_LAT-1 track the read on its way through the SRAM; the last
  // stage lines up with the registered rdata and drives rvalid.
  rd_tag_t          r_tag [RD_LAT+1];

  rr_pick #(
    .N  (NPORT),
    .IW (PIDX_W)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  // Winning command, muxed by the one-hot pick.
  always_comb begin
    w_win = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (w_pick_gnt[k]) begin
        w_win.we    = we[k];
        w_win.addr  = addr[k*AW +: AW];
        w_win.wdata = wdata[k*DW +: DW];
      end
    end
  end

`ifdef SRAM_ARB_TURNAROUND_EN
  // Pads show a read now (oe_n low) and a write wants the next slot.
  assign w_bubble = w_win.we & ~r_oe_n;
`else
  assign w_bubble = 1'b0;
`endif

  assign w_fire     = ~rst & en & w_pick_any & ~w_bubble;
  assign gnt        = w_fire ? w_pick_gnt : '0;
  assign w_ptr_next = (w_pick_idx == port_idx_t'(NPORT - 1)) ? '0 : w_pick_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_ce_n  <= CE_N_IDLE;
      r_we_n  <= WE_N_IDLE;
      r_oe_n  <= OE_N_IDLE;
      r_dq_oe <= DQ_OE_IDLE;
      r_addr  <= '0;
      r_dq_wr <= '0;
      r_rdata <= '0;
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= '0;
    end else begin
      if (w_fire) begin
        r_ptr   <= w_ptr_next;
        r_ce_n  <= 1'b0;
        r_we_n  <= ~w_win.we;
        r_oe_n  <= w_win.we;
        r_dq_oe <= w_win.we;
        r_addr  <= w_win.addr;
        if (w_win.we) r_dq_wr <= w_win.wdata;
      end else begin
        // Address and write data hold; only the controls go idle.
        r_ce_n  <= CE_N_IDLE;
        r_we_n  <= WE_N_IDLE;
        r_oe_n  <= OE_N_IDLE;
        r_dq_oe <= DQ_OE_IDLE;
      end
      r_tag[0] <= '{valid: w_fire & ~w_win.we, port: w_pick_idx};
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (r_tag[RD_LAT-1].valid) r_rdata <= sram_dq_rd;
    end
  end

  always_comb begin
    rvalid = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (r_tag[RD_LAT].valid && (r_tag[RD_LAT].port == port_idx_t'(k))) rvalid[k] = 1'b1;
    end
  end

  assign rdata      = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_ce_n  = r_ce_n;
  assign sram_we_n  = r_we_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_dq_wr = r_dq_wr;
  assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// tb_sram_rr_arbiter
// Two arbiters share the same request inputs: u_dut1 (RD_LAT=1) and u_dut3
// (RD_LAT=3). A behavioural SRAM (mem) is written from u_dut1's pads and read
// by both, u_dut3 through a two-register delay. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. Expected values come
// from constants and a reference model with its own memory copy (ref_mem).
// Honours SRAM_ARB_TURNAROUND_EN for the write-after-read bubble.
module tb_sram_rr_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 19;
  localparam int NPORT = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [NPORT-1:0]    req;
  logic [NPORT-1:0]    we;
  logic [NPORT*AW-1:0] addr;
  logic [NPORT*DW-1:0] wdata;

  logic [NPORT-1:0] gnt1, rvalid1, gnt3, rvalid3;
  logic [DW-1:0]    rdata1, dq_wr1, dq_rd1, rdata3, dq_wr3, dq_rd3;
  logic [AW-1:0]    sa1, sa3;
  logic             ce_n1, we_n1, oe_n1, dq_oe1, ce_n3, we_n3, oe_n3, dq_oe3;
  logic [3:0]       pads1, pads3;  // {ce_n, we_n, oe_n, dq_oe}

  logic [7:0]  mem [0:4095];
  logic [7:0]  ref_mem [0:4095];
  logic [7:0]  p1, p2;
  logic [26:0] exp_q[$];  // {due cycle[26:11], port[10:8], data[7:0]}
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.DW(DW), .AW(AW), .NPORT(NPORT), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1), .sram_addr(sa1),
    .sram_ce_n(ce_n1), .sram_we_n(we_n1), .sram_oe_n(oe_n1),
    .sram_dq_wr(dq_wr1), .sram_dq_oe(dq_oe1), .sram_dq_rd(dq_rd1));

  sram_rr_arbiter #(.DW(DW), .AW(AW), .NPORT(NPORT), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .sram_addr(sa3),
    .sram_ce_n(ce_n3), .sram_we_n(we_n3), .sram_oe_n(oe_n3),
    .sram_dq_wr(dq_wr3), .sram_dq_oe(dq_oe3), .sram_dq_rd(dq_rd3));

  assign pads1 = {ce_n1, we_n1, oe_n1, dq_oe1};
  assign pads3 = {ce_n3, we_n3, oe_n3, dq_oe3};

  // Behavioural SRAM: combinational read for RD_LAT=1, delayed for RD_LAT=3.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 37 + 11);
    mem[16] = 8'hA5;
    forever begin
      @(posedge clk);
      if (ce_n1 === 1'b0 && we_n1 === 1'b0) mem[sa1[11:0]] <= dq_wr1;
    end
  end
  assign dq_rd1 = mem[sa1[11:0]];
  always @(posedge clk) begin
    p1 <= mem[sa3[11:0]];
    p2 <= p1;
  end
  assign dq_rd3 = p2;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_port(input int k, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = r;
    we[k]  = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1; req = '0; we = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; req = 2'b11; we = '0; addr = '0; wdata = '0;
    tick();
    sample();
    n_tests++; if (gnt1 !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b expected 00", gnt1); end
    n_tests++; if (rvalid1 !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 00", rvalid1); end
    n_tests++; if (rdata1 !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h expected 00", rdata1); end
    n_tests++; if (sa1 !== 19'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", sa1); end
    n_tests++; if (dq_wr1 !== 8'h00) begin n_fail++; $display("FAIL rst_dqwr: got %h expected 00", dq_wr1); end
    n_tests++; if (pads1 !== 4'b1110) begin n_fail++; $display("FAIL rst_pads: got %b expected 1110", pads1); end
    n_tests++; if (pads3 !== 4'b1110) begin n_fail++; $display("FAIL rst_pads3: got %b expected 1110", pads3); end
    tick();
    rst = 1'b0; req = '0;
  endtask

  task automatic test_single_read();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 19'h00010, 8'h00);
    sample();
    n_tests++; if (gnt1 !== 2'b01) begin n_fail++; $display("FAIL t1_gnt: got %b expected 01", gnt1); end
    tick();
    set_port(0, 1'b0, 1'b0, 19'h0, 8'h00);
    sample();
    n_tests++; if (pads1 !== 4'b0100) begin n_fail++; $display("FAIL t1_pads: got %b expected 0100", pads1); end
    n_tests++; if (sa1 !== 19'h00010) begin n_fail++; $display("FAIL t1_addr: got %h expected 00010", sa1); end
    n_tests++; if (rvalid1 !== 2'b00) begin n_fail++; $display("FAIL t1_rv_early: got %b expected 00", rvalid1); end
    tick();
    sample();
    n_tests++; if (rvalid1 !== 2'b01) begin n_fail++; $display("FAIL t1_rvalid: got %b expected 01", rvalid1); end
    n_tests++; if (rdata1 !== 8'hA5) begin n_fail++; $display("FAIL t1_rdata: got %h expected a5", rdata1); end
    tick();
    sample();
    n_tests++; if (rvalid1 !== 2'b00) begin n_fail++; $display("FAIL t1_rv_pulse: got %b expected 00", rvalid1); end
  endtask

  task automatic test_alternate();
    logic [NPORT-1:0] e_gnt, e_rv;
    logic [DW-1:0]    e_rd;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      set_port(0, c < 4, 1'b0, 19'h00020, 8'h00);
      set_port(1, c < 4, 1'b0, 19'h00021, 8'h00);
      sample();
      e_gnt = (c < 4) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e_rv  = (c >= 2 && c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      e_rd  = (c % 2 == 0) ? ref_mem[12'h020] : ref_mem[12'h021];
      n_tests++; if (gnt1 !== e_gnt) begin n_fail++; $display("FAIL t2_gnt c%0d: got %b expected %b", c, gnt1, e_gnt); end
      n_tests++; if (rvalid1 !== e_rv) begin n_fail++; $display("FAIL t2_rvalid c%0d: got %b expected %b", c, rvalid1, e_rv); end
      if (e_rv != 2'b00) begin
        n_tests++; if (rdata1 !== e_rd) begin n_fail++; $display("FAIL t2_rdata c%0d: got %h expected %h", c, rdata1, e_rd); end
      end
      tick();
    end
  endtask

  task automatic test_write_read();
    apply_reset();
    set_port(1, 1'b1, 1'b1, 19'h00100, 8'h3C);
    sample();
    n_tests++; if (gnt1 !== 2'b10) begin n_fail++; $display("FAIL t3_wgnt: got %b expected 10", gnt1); end
    ref_mem[12'h100] = 8'h3C;
    tick();
    set_port(1, 1'b0, 1'b0, 19'h0, 8'h00);
    set_port(0, 1'b1, 1'b0, 19'h00100, 8'h00);
    sample();
    n_tests++; if (gnt1 !== 2'b01) begin n_fail++; $display("FAIL t3_rgnt: got %b expected 01", gnt1); end
    n_tests++; if (pads1 !== 4'b0011) begin n_fail++; $display("FAIL t3_wpads: got %b expected 0011", pads1); end
    n_tests++; if (dq_wr1 !== 8'h3C) begin n_fail++; $display("FAIL t3_dqwr: got %h expected 3c", dq_wr1); end
    n_tests++; if (sa1 !== 19'h00100) begin n_fail++; $display("FAIL t3_waddr: got %h expected 00100", sa1); end
    tick();
    set_port(0, 1'b0, 1'b0, 19'h0, 8'h00);
    sample();
    n_tests++; if (pads1 !== 4'b0100) begin n_fail++; $display("FAIL t3_rpads: got %b expected 0100", pads1); end
    tick();
    sample();
    n_tests++; if (rvalid1 !== 2'b01) begin n_fail++; $display("FAIL t3_rvalid: got %b expected 01", rvalid1); end
    n_tests++; if (rdata1 !== 8'h3C) begin n_fail++; $display("FAIL t3_rdata: got %h expected 3c", rdata1); end
    tick();
  endtask

  task automatic test_en_inflight();
    logic [NPORT-1:0] e_rv;
    apply_reset();
    set_port(0, 1'b1, 1'b0, 19'h00030, 8'h00);
    sample();
    n_tests++; if (gnt3 !== 2'b01) begin n_fail++; $display("FAIL t4_gnt0: got %b expected 01", gnt3); end
    tick();
    for (int c = 1; c < 7; c++) begin
      en = 1'b0;
      set_port(0, 1'b1, 1'b0, 19'h00031, 8'h00);
      set_port(1, 1'b1, 1'b0, 19'h00032, 8'h00);
      sample();
      n_tests++; if (gnt3 !== 2'b00) begin n_fail++; $display("FAIL t4_gnt c%0d: got %b expected 00", c, gnt3); end
      e_rv = (c == 4) ? 2'b01 : 2'b00;
      n_tests++; if (rvalid3 !== e_rv) begin n_fail++; $display("FAIL t4_rvalid c%0d: got %b expected %b", c, rvalid3, e_rv); end
      if (c == 4) begin
        n_tests++; if (rdata3 !== ref_mem[12'h030]) begin n_fail++; $display("FAIL t4_rdata: got %h expected %h", rdata3, ref_mem[12'h030]); end
      end
      if (c >= 2) begin
        n_tests++; if (pads3 !== 4'b1110) begin n_fail++; $display("FAIL t4_idle c%0d: got %b expected 1110", c, pads3); end
      end
      tick();
    end
    req = '0; en = 1'b1;
  endtask

  task automatic test_turnaround();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 19'h00040, 8'h00);
    sample();
    n_tests++; if (gnt1 !== 2'b01) begin n_fail++; $display("FAIL t5_rgnt: got %b expected 01", gnt1); end
    tick();
    set_port(0, 1'b0, 1'b0, 19'h0, 8'h00);
    set_port(1, 1'b1, 1'b1, 19'h00041, 8'h5A);
    ref_mem[12'h041] = 8'h5A;
`ifdef SRAM_ARB_TURNAROUND_EN
    sample();
    n_tests++; if (gnt1 !== 2'b00) begin n_fail++; $display("FAIL t5_bubble: got %b expected 00", gnt1); end
    tick();
    sample();
    n_tests++; if (pads1 !== 4'b1110) begin n_fail++; $display("FAIL t5_idle: got %b expected 1110", pads1); end
    n_tests++; if (gnt1 !== 2'b10) begin n_fail++; $display("FAIL t5_wgnt: got %b expected 10", gnt1); end
`else
    sample();
    n_tests++; if (gnt1 !== 2'b10) begin n_fail++; $display("FAIL t5_wgnt: got %b expected 10", gnt1); end
`endif
    tick();
    set_port(1, 1'b0, 1'b0, 19'h0, 8'h00);
    sample();
    n_tests++; if (pads1 !== 4'b0011) begin n_fail++; $display("FAIL t5_wpads: got %b expected 0011", pads1); end
    n_tests++; if (dq_wr1 !== 8'h5A) begin n_fail++; $display("FAIL t5_dqwr: got %h expected 5a", dq_wr1); end
    tick();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_port(0, 1'b1, 1'b0, 19'h00050, 8'h00);
    sample();
    n_tests++; if (gnt3 !== 2'b01) begin n_fail++; $display("FAIL t6_gnt0: got %b expected 01", gnt3); end
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_port(0, 1'b1, 1'b0, 19'h00051, 8'h00);
    set_port(1, 1'b1, 1'b0, 19'h00052, 8'h00);
    sample();
    n_tests++; if (gnt3 !== 2'b01) begin n_fail++; $display("FAIL t6_ptr0: got %b expected 01", gnt3); end
    n_tests++; if (pads3 !== 4'b1110) begin n_fail++; $display("FAIL t6_pads: got %b expected 1110", pads3); end
    n_tests++; if (sa3 !== 19'h0) begin n_fail++; $display("FAIL t6_addr: got %h expected 0", sa3); end
    n_tests++; if (rdata3 !== 8'h00) begin n_fail++; $display("FAIL t6_rdata: got %h expected 00", rdata3); end
    tick();
    req = '0;
    for (int c = 4; c < 8; c++) begin
      sample();
      if (c < 7) begin
        n_tests++; if (rvalid3 !== 2'b00) begin n_fail++; $display("FAIL t6_dropped c%0d: got %b expected 00", c, rvalid3); end
      end else begin
        n_tests++; if (rvalid3 !== 2'b01) begin n_fail++; $display("FAIL t6_newrv: got %b expected 01", rvalid3); end
        n_tests++; if (rdata3 !== ref_mem[12'h051]) begin n_fail++; $display("FAIL t6_newrd: got %h expected %h", rdata3, ref_mem[12'h051]); end
      end
      tick();
    end
  endtask

  // Reference model: strict rotation from ptr, bubble rule, and a shadow
  // memory where every read returns the latest write granted before it.
  task automatic test_random(input int ncyc);
    logic [NPORT-1:0] p_req, p_we, e_gnt, e_rv;
    logic [AW-1:0]    p_addr [NPORT];
    logic [DW-1:0]    p_wd [NPORT];
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_dqwr;
    logic [3:0]       m_ctrl;
    logic             m_last_rd, bubble, fire;
    logic [26:0]      e;
    int               m_ptr, win;
    apply_reset();
    exp_q.delete();
    m_ptr = 0; m_last_rd = 1'b0; m_ctrl = 4'b1110; m_addr = '0; m_dqwr = '0; p_req = '0; p_we = '0;
    for (int k = 0; k < NPORT; k++) begin p_addr[k] = '0; p_wd[k] = '0; end
    for (int c = 0; c < ncyc; c++) begin
      for (int k = 0; k < NPORT; k++) begin
        if (!p_req[k] && c < ncyc - 5 && $urandom_range(0, 1) == 1) begin
          p_req[k]  = 1'b1;
          p_we[k]   = 1'($urandom_range(0, 1));
          p_addr[k] = AW'($urandom_range(0, 63));
          p_wd[k]   = DW'($urandom);
        end
        set_port(k, p_req[k], p_we[k], p_addr[k], p_wd[k]);
      end
      en = ($urandom_range(0, 7) != 0);
      sample();
      win = -1;
      for (int i = 0; i < NPORT; i++) if (win < 0 && p_req[(m_ptr + i) % NPORT]) win = (m_ptr + i) % NPORT;
      bubble = 1'b0;
`ifdef SRAM_ARB_TURNAROUND_EN
      if (win >= 0) bubble = p_we[win] && m_last_rd;
`endif
      fire  = en && (win >= 0) && !bubble;
      e_gnt = fire ? (NPORT'(1) << win) : '0;
      n_tests++; if (gnt1 !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt1, e_gnt); end
      n_tests++;
      if ({pads1, sa1, dq_wr1} !== {m_ctrl, m_addr, m_dqwr}) begin
        n_fail++; $display("FAIL rnd_pads c%0d: got %b/%h/%h expected %b/%h/%h", c, pads1, sa1, dq_wr1, m_ctrl, m_addr, m_dqwr);
      end
      e_rv = '0; e = '0;
      if (exp_q.size() > 0 && exp_q[0][26:11] == 16'(c)) begin
        e = exp_q.pop_front();
        e_rv = NPORT'(1) << e[10:8];
      end
      n_tests++; if (rvalid1 !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", c, rvalid1, e_rv); end
      if (e_rv != '0) begin
        n_tests++; if (rdata1 !== e[7:0]) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h expected %h", c, rdata1, e[7:0]); end
      end
      if (fire) begin
        m_ptr  = (win + 1) % NPORT;
        m_addr = p_addr[win];
        if (p_we[win]) begin
          ref_mem[p_addr[win][11:0]] = p_wd[win];
          m_dqwr = p_wd[win];
          m_ctrl = 4'b0011;
        end else begin
          exp_q.push_back({16'(c + 2), 3'(win), ref_mem[p_addr[win][11:0]]});
          m_ctrl = 4'b0100;
        end
        m_last_rd  = !p_we[win];
        p_req[win] = 1'b0;
      end else begin
        m_ctrl = 4'b1110;
        m_last_rd = 1'b0;
      end
      tick();
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d pending expected 0", exp_q.size()); end
    req = '0; en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[16] = 8'hA5;
    rst = 1'b1; en = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    test_reset();
    test_single_read();
    test_alternate();
    test_write_read();
    test_en_inflight();
    test_turnaround();
    test_reset_midflight();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
